timer_irq_ctrl: RTL and testbench

TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

---
 rtl/timer_irq_ctrl.sv | 146 ++++++++++++++
 tb/tb_timer_irq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
// Timer with a single interrupt source and a three-state handshake to the pipeline.
//
// The timer is memory-mapped as three registers:
//   TH   0x4000_0000  reload value
//   TL   0x4000_0004  counter; on overflow it reloads from TH instead of wrapping
//   TCON 0x4000_0008  bit0 timer enable, bit1 interrupt enable, bit2 interrupt status
//
// The interrupt FSM moves IDLE -> PEND when status and enable are both set. It moves
// PEND -> KERNEL when the pipeline accepts the request, and KERNEL -> IDLE on eret.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   bus_addr/wdata/we/re   MEM-stage load/store bus
//   bus_rdata              combinational load data (0 when not a mapped read)
//   pipe_ready             pipeline is at a safe point to take an interrupt
//   irq_ack                pipeline has flushed and redirected to the handler
//   eret                   handler return executed
//   irq                    interrupt request (PEND and pipe_ready)
//   kernel                 handler in progress
//   irq_pending            interrupt latched but not yet taken
module timer_irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  input  logic        pipe_ready,
  input  logic        irq_ack,
  input  logic        eret,
  output logic        irq,
  output logic        kernel,
  output logic        irq_pending
);

  localparam logic [31:0] AddrTh   = 32'h4000_0000;
  localparam logic [31:0] AddrTl   = 32'h4000_0004;
  localparam logic [31:0] AddrTcon = 32'h4000_0008;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StKernel
  } state_e;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  state_e      state_q, state_d;

  logic wr_th, wr_tl, wr_tcon;
  logic overflow, ovf_set, irq_cond;

  assign wr_th   = bus_we && (bus_addr == AddrTh);
  assign wr_tl   = bus_we && (bus_addr == AddrTl);
  assign wr_tcon = bus_we && (bus_addr == AddrTcon);

  assign overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_set  = overflow && tcon_q[1];
  assign irq_cond = tcon_q[2] && tcon_q[1];

  // Register next-state. A bus write to TL beats the increment or reload, and the
  // overflow status is ORed into a same-cycle TCON write so it is never lost.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (wr_th) begin
      th_d = bus_wdata;
    end
    if (wr_tl) begin
      tl_d = bus_wdata;
    end else if (tcon_q[0]) begin
      tl_d = overflow ? th_q : tl_q + 32'd1;
    end
    if (wr_tcon) begin
      tcon_d = {bus_wdata[2] | ovf_set, bus_wdata[1:0]};
    end else begin
      tcon_d = {tcon_q[2] | ovf_set, tcon_q[1:0]};
    end
  end

  // Combinational read port.
  always_comb begin
    bus_rdata = '0;
    if (bus_re) begin
      if (bus_addr == AddrTh) begin
        bus_rdata = th_q;
      end else if (bus_addr == AddrTl) begin
        bus_rdata = tl_q;
      end else if (bus_addr == AddrTcon) begin
        bus_rdata = {29'd0, tcon_q};
      end
    end
  end

  // Interrupt FSM next-state and outputs.
  always_comb begin
    state_d     = state_q;
    irq         = 1'b0;
    kernel      = 1'b0;
    irq_pending = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (irq_cond) begin
          state_d = StPend;
        end
      end
      StPend: begin
        irq_pending = 1'b1;
        irq         = pipe_ready;
        // Acceptance wins over a same-cycle drop of the request condition.
        if (pipe_ready && irq_ack) begin
          state_d = StKernel;
        end else if (!irq_cond) begin
          state_d = StIdle;
        end
      end
      StKernel: begin
        kernel = 1'b1;
        if (eret) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q    <= '0;
      tl_q    <= '0;
      tcon_q  <= '0;
      state_q <= StIdle;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      tcon_q  <= tcon_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: directed scenarios followed by random bus and
// pipeline traffic. Everything is compared against a cycle-level behavioural model.
module tb_timer_irq_ctrl;

  localparam logic [31:0] AddrTh   = 32'h4000_0000;
  localparam logic [31:0] AddrTl   = 32'h4000_0004;
  localparam logic [31:0] AddrTcon = 32'h4000_0008;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, pr, ack, er;
  logic        irq, kernel, irq_pending;

  timer_irq_ctrl dut (
    .clk         (clk),
    .reset       (reset_n),
    .bus_addr    (addr),
    .bus_wdata   (wdata),
    .bus_we      (we),
    .bus_re      (re),
    .bus_rdata   (rdata),
    .pipe_ready  (pr),
    .irq_ack     (ack),
    .eret        (er),
    .irq         (irq),
    .kernel      (kernel),
    .irq_pending (irq_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: register contents plus two flags describing the interrupt.
  logic [31:0] m_th, m_tl;
  logic [2:0]  m_tcon;
  bit          m_waiting;   // interrupt latched, not yet taken
  bit          m_handler;   // handler running

  logic [31:0] obs_rdata;
  logic        obs_irq, obs_kernel, obs_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic r);
    if (!r) return 32'd0;
    if (a == AddrTh) return m_th;
    if (a == AddrTl) return m_tl;
    if (a == AddrTcon) return {29'd0, m_tcon};
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_tcon = 0; m_waiting = 0; m_handler = 0;
  endtask

  // Advance the model by one clock using the inputs held during the cycle.
  task automatic m_step();
    bit          running, at_max, want;
    logic [31:0] n_th, n_tl;
    logic [2:0]  n_tcon;
    running = m_tcon[0];
    at_max  = running && (m_tl == 32'hFFFF_FFFF);
    want    = m_tcon[2] && m_tcon[1];
    n_th    = (we && addr == AddrTh) ? wdata : m_th;
    if (we && addr == AddrTl)      n_tl = wdata;
    else if (at_max)               n_tl = m_th;
    else if (running)              n_tl = m_tl + 1;
    else                           n_tl = m_tl;
    n_tcon = (we && addr == AddrTcon) ? wdata[2:0] : m_tcon;
    if (at_max && m_tcon[1]) n_tcon[2] = 1'b1;
    if (m_handler) begin
      if (er) m_handler = 0;
    end else if (m_waiting) begin
      if (pr && ack) begin
        m_waiting = 0;
        m_handler = 1;
      end else if (!want) begin
        m_waiting = 0;
      end
    end else if (want) begin
      m_waiting = 1;
    end
    m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
  endtask

  // Called at posedge+1 with inputs set; compares mid-cycle, then steps the model.
  task automatic tick();
    #3;
    obs_rdata  = rdata;
    obs_irq    = irq;
    obs_kernel = kernel;
    obs_pend   = irq_pending;
    check("rdata", rdata, m_read(addr, re));
    check("irq", {31'd0, irq}, {31'd0, m_waiting && pr});
    check("kernel", {31'd0, kernel}, {31'd0, m_handler});
    check("irq_pending", {31'd0, irq_pending}, {31'd0, m_waiting});
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1; tick(); we = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; re = 1; tick(); re = 0;
  endtask

  task automatic wait_tl_max();
    int n = 0;
    while (m_tl != 32'hFFFF_FFFF && n < 60) begin
      tick();
      n++;
    end
    check("wait_tl_max_timeout", {31'd0, m_tl == 32'hFFFF_FFFF}, 32'd1);
  endtask

  task automatic wait_pending();
    int n = 0;
    while (!m_waiting && n < 60) begin
      tick();
      n++;
    end
    check("wait_pending_timeout", {31'd0, m_waiting}, 32'd1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic reset_pulse();
    reset_n = 0;
    re = 1; addr = AddrTl;
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_kernel", {31'd0, kernel}, 32'd0);
    check("rst_pending", {31'd0, irq_pending}, 32'd0);
    check("rst_tl", rdata, 32'd0);
    addr = AddrTcon; #1;
    check("rst_tcon", rdata, 32'd0);
    addr = AddrTh; #1;
    check("rst_th", rdata, 32'd0);
    m_reset();
    re = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; addr = 0; wdata = 0; we = 0; re = 0; pr = 0; ack = 0; er = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;

    // Overflow reload and status set, then request with pipe_ready.
    wr(AddrTh, 32'hFFFF_FFF0);
    wr(AddrTl, 32'hFFFF_FFFE);
    wr(AddrTcon, 32'd3);
    rd(AddrTl); check("tl_fe", obs_rdata, 32'hFFFF_FFFE);
    rd(AddrTl); check("tl_ff", obs_rdata, 32'hFFFF_FFFF);
    rd(AddrTl); check("tl_reload", obs_rdata, 32'hFFFF_FFF0);
    check("idle_no_pend", {31'd0, obs_pend}, 32'd0);
    pr = 1;
    rd(AddrTcon); check("tcon_7", obs_rdata, 32'd7);
    check("pend_irq", {31'd0, obs_irq}, 32'd1);

    // Pipeline not ready: request withheld but still pending.
    pr = 0;
    repeat (5) begin
      tick();
      check("hold_irq0", {31'd0, obs_irq}, 32'd0);
      check("hold_pend1", {31'd0, obs_pend}, 32'd1);
    end
    pr = 1; ack = 1; tick(); ack = 0;
    tick(); check("enter_kernel", {31'd0, obs_kernel}, 32'd1);

    // Second overflow in the handler does not nest.
    wr(AddrTl, 32'hFFFF_FFFE);
    repeat (4) begin
      tick();
      check("kern_irq0", {31'd0, obs_irq}, 32'd0);
    end
    wr(AddrTcon, 32'd3);
    er = 1; tick(); er = 0;
    repeat (3) begin
      tick();
      check("ret_irq0", {31'd0, obs_irq}, 32'd0);
      check("ret_idle", {31'd0, obs_pend | obs_kernel}, 32'd0);
    end

    // Return without clearing status: one IDLE cycle, then PEND again.
    wr(AddrTl, 32'hFFFF_FFFE);
    wait_pending();
    ack = 1; tick(); ack = 0;
    tick(); check("kernel2", {31'd0, obs_kernel}, 32'd1);
    er = 1; tick(); er = 0;
    tick();
    check("gap_idle", {29'd0, obs_irq, obs_kernel, obs_pend}, 32'd0);
    tick();
    check("repend_irq", {31'd0, obs_irq}, 32'd1);
    check("repend_pend", {31'd0, obs_pend}, 32'd1);

    // Overflow coincident with a TCON write, then with a TL write.
    pr = 0;
    wr(AddrTcon, 32'd0);
    wr(AddrTl, 32'hFFFF_FFFD);
    wr(AddrTcon, 32'd3);
    wait_tl_max();
    wr(AddrTcon, 32'd3);
    rd(AddrTcon); check("tcon_same_cycle", obs_rdata, 32'd7);
    wait_tl_max();
    wr(AddrTl, 32'd5);
    rd(AddrTl); check("tl_write_wins", obs_rdata, 32'd5);

    // Reset while pending, then while in the handler.
    tick(); tick();
    check("pre_rst_pend", {31'd0, obs_pend}, 32'd1);
    reset_pulse();
    repeat (10) begin
      rd(AddrTcon);
      check("post_rst_tcon", obs_rdata, 32'd0);
      check("post_rst_pend", {31'd0, obs_pend}, 32'd0);
    end
    wr(AddrTh, 32'hFFFF_FFF0);
    wr(AddrTl, 32'hFFFF_FFFE);
    wr(AddrTcon, 32'd3);
    wait_pending();
    pr = 1; ack = 1; tick(); ack = 0;
    tick(); check("pre_rst_kernel", {31'd0, obs_kernel}, 32'd1);
    reset_pulse();
    repeat (10) begin
      tick();
      check("post_rst2", {29'd0, obs_irq, obs_kernel, obs_pend}, 32'd0);
    end

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] pick;
      pick = $urandom_range(0, 5);
      case (pick)
        0: addr = AddrTh;
        1, 2: addr = AddrTl;
        3, 4: addr = AddrTcon;
        default: addr = 32'h4000_000C + 4 * $urandom_range(0, 3);
      endcase
      we = ($urandom_range(0, 9) < 3);
      re = ($urandom_range(0, 9) < 6);
      if (addr == AddrTl) wdata = 32'hFFFF_FFFF - $urandom_range(0, 20);
      else if (addr == AddrTh) wdata = 32'hFFFF_FFE0 + $urandom_range(0, 31);
      else wdata = $urandom;
      if (addr == AddrTcon && we) wdata = {$urandom, 3'b000} | 32'($urandom_range(0, 7));
      pr  = $urandom_range(0, 1);
      ack = ($urandom_range(0, 9) < 3);
      // Keep acceptance away from the cycle after the request condition has dropped.
      if (m_waiting && !(m_tcon[2] && m_tcon[1])) ack = 0;
      er  = ($urandom_range(0, 9) < 2);
      tick();
    end
    we = 0; re = 0; ack = 0; er = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
